// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding, the default operand width and a counter-width helper.
package serial_add_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Sequencer states: waiting, shifting bits through the cell, result valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes bits 0..width-1 (never less than 1 bit).
  function automatic int unsigned cntWidth(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic hardware in the serial
// datapath, reused once per bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry-out of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted
// start, then one full-adder cell processes one bit per cycle, LSB first.
// The visible result (sum/cout/ovf) only changes when the last bit has
// been processed, so it stays stable while the next operation runs.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = int'(cntWidth(WIDTH));
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Internal reset: asserts together with rst_n, releases two clocks later.
  logic [1:0] rstSync_q;
  logic       rstInt_n;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cellS;
  logic cellCo;

  // Reset synchronizer: asynchronous assertion, release aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstInt_n = rstSync_q[1];

  // The bit cell always sees the current LSBs and the running carry.
  fa_cell uFaCell (
    .a  (opA_q[0]),
    .b  (opB_q[0]),
    .ci (carry_q),
    .s  (cellS),
    .co (cellCo)
  );

  // State and datapath registers; everything clears as soon as reset asserts.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update. Subtraction is A + ~B + 1, so the carry
  // register is preset to 1 and B is inverted at capture time. Starts that
  // arrive while RUN is active are simply not looked at.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        opA_d   = opA_q >> 1;
        opB_d   = opB_q >> 1;
        acc_d   = {cellS, acc_q[WIDTH-1:1]};
        carry_d = cellCo;
        if (cnt_q == LAST) begin
          // Last bit: publish the result. The carry into the MSB is the
          // carry register feeding the cell this cycle.
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = {cellS, acc_q[WIDTH-1:1]};
          cout_d  = cellCo;
          ovf_d   = carry_q ^ cellCo;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8): a table of hand-computed
// add/subtract vectors plus sequences for ignored start, reset during an
// operation and back-to-back operation with start held high.
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int               testsRun = 0;
  int               testsFailed = 0;
  logic [WIDTH-1:0] prevSum = '0;

  typedef struct {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] expSum;
    logic             expCout;
    logic             expOvf;
  } vec_t;

  vec_t vecs[12];

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one operation with start for a single cycle, then scramble the
  // operand inputs so only the accepting edge matters. Returns at the first
  // sample after the accepting edge (RUN cycle 1).
  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic c);
    @(negedge clk);
    sub = s; a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = 8'hC3; sub = ~s; cin = ~c;
  endtask

  // Follow an operation from RUN cycle startCyc until done, checking
  // latency, busy duration, the result, and that done is a single pulse.
  task automatic waitDone(input string tag, input int startCyc,
                          input logic [WIDTH-1:0] expSum, input logic expCout,
                          input logic expOvf);
    int busyCnt;
    int doneCyc;
    busyCnt = startCyc - 1;
    doneCyc = 0;
    checkOutput({tag, " sumHeldInRun"}, 32'(sum), 32'(prevSum));
    for (int cyc = startCyc; cyc <= 20; cyc++) begin
      if (done) begin
        doneCyc = cyc;
        break;
      end
      if (busy) busyCnt++;
      @(negedge clk);
    end
    checkOutput({tag, " latency"}, 32'(doneCyc), 32'd9);
    checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'd8);
    checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, " busyAtDone"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, " donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, " sumHeld"}, 32'(sum), 32'(expSum));
    prevSum = expSum;
  endtask

  initial begin
    int doneSeen;
    int busySeen;
    int doneCount;

    //           sub   a      b      cin   sum    cout  ovf
    vecs[0]  = '{1'b0, 8'h35, 8'h0A, 1'b1, 8'h40, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h7F, 8'h80, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
      waitDone($sformatf("vec%0d", i), 1, vecs[i].expSum, vecs[i].expCout,
               vecs[i].expOvf);
    end

    // Start re-pulsed in RUN cycle 3 with different operands is ignored.
    applyStimulus(1'b0, 8'h35, 8'h0A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("repulse", 4, 8'h40, 1'b0, 1'b0);
    doneSeen = 0;
    busySeen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done) doneSeen++;
      if (busy) busySeen++;
      @(negedge clk);
    end
    checkOutput("repulse noExtraDone", 32'(doneSeen), 32'd0);
    checkOutput("repulse notQueued", 32'(busySeen), 32'd0);

    // Reset asserted in RUN cycle 4 aborts the operation.
    applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset busy", 32'(busy), 32'd0);
    checkOutput("midReset done", 32'(done), 32'd0);
    checkOutput("midReset sum", 32'(sum), 32'd0);
    checkOutput("midReset cout", 32'(cout), 32'd0);
    checkOutput("midReset ovf", 32'(ovf), 32'd0);
    prevSum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("midReset noDone", 32'(doneSeen), 32'd0);
    applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
    waitDone("afterReset", 1, 8'h80, 1'b0, 1'b1);

    // Start held high: back-to-back operations with done every 9 cycles.
    @(negedge clk);
    sub = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    doneCount = 0;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        checkOutput($sformatf("b2b done%0d cycle", doneCount), 32'(cyc),
                    32'(9 * doneCount));
        checkOutput($sformatf("b2b done%0d sum", doneCount), 32'(sum), 32'h03);
      end
    end
    start = 1'b0;
    checkOutput("b2b doneCount", 32'(doneCount), 32'd3);
    repeat (2) @(negedge clk);
    checkOutput("b2b idleAfter", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
